// File: rtl/idelay_tap_cal_pkg.sv
// Shared types and constants for the IDELAYE2 tap calibration sequencer.
// Holds the FSM state encoding, the tap and window-length widths, and the window-centre helper.
package idelay_cal_pkg;

    localparam int TAP_W   = 5;
    localparam int TAP_MAX = 31;
    localparam int LEN_W   = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CRST,
        S_WRDY,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_ACCUM,
        S_APPLY,
        S_DONE
    } cal_state_t;

    // Lower-middle tap of a window; an empty window maps to tap 0.
    function automatic logic [TAP_W-1:0] win_centre(input logic [TAP_W-1:0] start,
                                                    input logic [LEN_W-1:0] len);
        if (len == '0)
            return '0;
        return TAP_W'({1'b0, start} + ((len - LEN_W'(1)) >> 1));
    endfunction

endpackage

// File: rtl/idelay_tap_cal_if.sv
// Handshake/status bundle between the calibration sequencer, the ADC setup logic and the delay bank.
// The master modport is taken by the sequencer; the slave modport by its environment.
interface idelay_tap_cal_if #(
    parameter int NUM_LANES = 14
);
    logic                   cal_start_i;
    logic                   idelayctrl_rdy_i;
    logic [NUM_LANES-1:0]   adc_dat_i;
    logic [NUM_LANES-1:0]   pattern_i;
    logic                   idelayctrl_rst_o;
    logic [5*NUM_LANES-1:0] cntvalue_o;
    logic                   ld_o;
    logic                   busy_o;
    logic                   done_o;
    logic [NUM_LANES-1:0]   fail_o;
    logic                   err_o;

    modport master (
        input  cal_start_i, idelayctrl_rdy_i, adc_dat_i, pattern_i,
        output idelayctrl_rst_o, cntvalue_o, ld_o, busy_o, done_o, fail_o, err_o
    );

    modport slave (
        output cal_start_i, idelayctrl_rdy_i, adc_dat_i, pattern_i,
        input  idelayctrl_rst_o, cntvalue_o, ld_o, busy_o, done_o, fail_o, err_o
    );
endinterface

// File: rtl/idelay_tap_cal_win_track.sv
// Per-lane passing-window tracker: follows the current run of passing taps and keeps the longest.
// Ties keep the earlier window because the best window is only replaced on a strictly longer run.
module idelay_win_track
    import idelay_cal_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             acc,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] centre,
    output logic             fail
);
    logic [LEN_W-1:0] run_len;
    logic [TAP_W-1:0] run_start;
    logic [LEN_W-1:0] best_len;
    logic [TAP_W-1:0] best_start;
    logic [LEN_W-1:0] run_next;
    logic [TAP_W-1:0] start_next;

    always_comb begin
        run_next   = run_len + LEN_W'(1);
        start_next = (run_len == '0) ? tap : run_start;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (acc) begin
            if (pass) begin
                run_len   <= run_next;
                run_start <= start_next;
                if (run_next > best_len) begin
                    best_len   <= run_next;
                    best_start <= start_next;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

    assign centre = win_centre(best_start, best_len);
    assign fail   = (best_len == '0);

endmodule

// File: rtl/idelay_tap_cal.sv
// IDELAYE2 VAR_LOAD tap calibration: resets IDELAYCTRL, sweeps taps 0..31 on all lanes, loads window centres.
// Optional macro IDELAY_CAL_RDY_TIMEOUT_EN bounds the wait for IDELAYCTRL RDY to RDY_TIMEOUT cycles.
module idelay_tap_cal
    import idelay_cal_pkg::*;
#(
    parameter int NUM_LANES     = 14,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLES       = 256,
    parameter int RDY_TIMEOUT   = 4096
) (
    input  logic               clk_i,
    input  logic               rst_i,
    idelay_tap_cal_if.master   bus
);
    cal_state_t             state;
    logic [TAP_W-1:0]       tap;
    logic [15:0]            cnt;
    logic [NUM_LANES-1:0]   mism;
    logic [TAP_W-1:0]       centre [NUM_LANES];
    logic [NUM_LANES-1:0]   lane_fail;
    logic [5*NUM_LANES-1:0] centre_word;
    logic                   start_go;
    logic                   trk_acc;

`ifdef IDELAY_CAL_RDY_TIMEOUT_EN
    logic [$clog2(RDY_TIMEOUT+1)-1:0] wait_cnt;
`endif

    assign start_go = bus.cal_start_i && (state == S_IDLE || state == S_DONE);
    assign trk_acc  = (state == S_ACCUM);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        idelay_win_track u_trk (
            .clk    (clk_i),
            .rst    (rst_i),
            .clr    (start_go),
            .acc    (trk_acc),
            .pass   (~mism[k]),
            .tap    (tap),
            .centre (centre[k]),
            .fail   (lane_fail[k])
        );
        assign centre_word[5*k +: 5] = centre[k];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                <= S_IDLE;
            tap                  <= '0;
            cnt                  <= '0;
            mism                 <= '0;
            bus.idelayctrl_rst_o <= 1'b0;
            bus.cntvalue_o       <= '0;
            bus.ld_o             <= 1'b0;
            bus.busy_o           <= 1'b0;
            bus.done_o           <= 1'b0;
            bus.fail_o           <= '0;
            bus.err_o            <= 1'b0;
`ifdef IDELAY_CAL_RDY_TIMEOUT_EN
            wait_cnt             <= '0;
`endif
        end else begin
            bus.ld_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.cal_start_i) begin
                        bus.done_o           <= 1'b0;
                        bus.fail_o           <= '0;
                        bus.err_o            <= 1'b0;
                        bus.busy_o           <= 1'b1;
                        bus.idelayctrl_rst_o <= 1'b1;
                        tap                  <= '0;
                        cnt                  <= '0;
                        mism                 <= '0;
                        state                <= S_CRST;
                    end
                end
                S_CRST: begin
                    if (cnt == 16'(RST_CYCLES - 1)) begin
                        cnt                  <= '0;
                        bus.idelayctrl_rst_o <= 1'b0;
`ifdef IDELAY_CAL_RDY_TIMEOUT_EN
                        wait_cnt             <= '0;
`endif
                        state                <= S_WRDY;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WRDY: begin
                    if (bus.idelayctrl_rdy_i) begin
                        bus.cntvalue_o <= {NUM_LANES{tap}};
                        bus.ld_o       <= 1'b1;
                        state          <= S_LOAD;
                    end
`ifdef IDELAY_CAL_RDY_TIMEOUT_EN
                    // Give up with the delay taps left as they were.
                    else if (wait_cnt == ($bits(wait_cnt))'(RDY_TIMEOUT - 1)) begin
                        bus.err_o  <= 1'b1;
                        bus.fail_o <= '1;
                        bus.busy_o <= 1'b0;
                        bus.done_o <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == 16'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    mism <= mism | (bus.adc_dat_i ^ bus.pattern_i);
                    if (cnt == 16'(SAMPLES - 1)) begin
                        cnt   <= '0;
                        state <= S_ACCUM;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_ACCUM: begin
                    mism <= '0;
                    if (tap == TAP_W'(TAP_MAX)) begin
                        state <= S_APPLY;
                    end else begin
                        tap            <= tap + TAP_W'(1);
                        bus.cntvalue_o <= {NUM_LANES{tap + TAP_W'(1)}};
                        bus.ld_o       <= 1'b1;
                        state          <= S_LOAD;
                    end
                end
                // Trackers have absorbed the last tap by now, so the centres are final.
                S_APPLY: begin
                    bus.cntvalue_o <= centre_word;
                    bus.fail_o     <= lane_fail;
                    bus.ld_o       <= 1'b1;
                    bus.busy_o     <= 1'b0;
                    bus.done_o     <= 1'b1;
                    state          <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Directed bench for idelay_tap_cal: behavioural IDELAY bank and IDELAYCTRL around the DUT, scoreboarded results.
// Expected per-lane centres are constants from the window layouts; the RDY-timeout run needs IDELAY_CAL_RDY_TIMEOUT_EN.
module tb_idelay_tap_cal;
    localparam int NL = 14;

    typedef struct {
        string           tag;
        logic [5*NL-1:0] cnt;
        logic [NL-1:0]   fail;
        logic            err;
        int              ld_n;
        int              rst_n;
        int              lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idelay_tap_cal_if #(.NUM_LANES(NL)) bus ();

    idelay_tap_cal dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t        exp_q [$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] pass_mask [NL];
    logic [4:0]  lane_tap [NL] = '{default: 5'd0};
    int          rdy_delay   = 0;
    logic        rdy_hold_low = 1'b0;
    int          rdy_cnt     = 0;
    int          ld_cnt      = 0;
    int          rst_hi_cnt  = 0;

    // Delay bank: each lane latches its tap on LD; a lane reads the pattern only inside its pass window.
    always @(posedge clk) begin
        if (bus.ld_o)
            for (int k = 0; k < NL; k++) lane_tap[k] <= bus.cntvalue_o[5*k +: 5];
        if (bus.ld_o) ld_cnt <= ld_cnt + 1;
        if (bus.idelayctrl_rst_o) begin
            rst_hi_cnt <= rst_hi_cnt + 1;
            rdy_cnt    <= 0;
        end else if (rdy_cnt < 100000) begin
            rdy_cnt <= rdy_cnt + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < NL; k++)
            bus.adc_dat_i[k] = bus.pattern_i[k] ^ ~pass_mask[k][lane_tap[k]];
        bus.idelayctrl_rdy_i = !bus.idelayctrl_rst_o && !rdy_hold_low && (rdy_cnt >= rdy_delay);
    end

    function automatic logic [31:0] win(input int a, input int b);
        logic [31:0] m;
        m = '0;
        for (int t = a; t <= b; t++) m[t] = 1'b1;
        return m;
    endfunction

    function automatic logic [5*NL-1:0] rep(input logic [4:0] v);
        return {NL{v}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_cal(input exp_t e, input int rdy_d, input bit poke);
        int cycles;
        int ld0;
        int r0;
        exp_t got;
        rdy_delay = rdy_d;
        exp_q.push_back(e);
        ld0 = ld_cnt;
        r0  = rst_hi_cnt;
        @(negedge clk);
        bus.cal_start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.cal_start_i = 1'b0;
        chk({e.tag, "_busy_start"}, bus.busy_o, 1'b1);
        cycles = 0;
        while (!bus.done_o && cycles < 20000) begin
            @(posedge clk);
            #1;
            cycles++;
            bus.cal_start_i = poke && (cycles == 300);
        end
        bus.cal_start_i = 1'b0;
        got = exp_q.pop_front();
        chk({got.tag, "_done"},    bus.done_o, 1'b1);
        chk({got.tag, "_latency"}, cycles, got.lat);
        chk({got.tag, "_busy"},    bus.busy_o, 1'b0);
        chk({got.tag, "_fail"},    bus.fail_o, got.fail);
        chk({got.tag, "_err"},     bus.err_o, got.err);
        @(posedge clk);
        #1;
        chk({got.tag, "_cntvalue"}, bus.cntvalue_o, got.cnt);
        chk({got.tag, "_ld_pulses"}, ld_cnt - ld0, got.ld_n);
        chk({got.tag, "_rst_cycles"}, rst_hi_cnt - r0, got.rst_n);
        repeat (5) @(posedge clk);
        #1;
        chk({got.tag, "_cnt_hold"}, bus.cntvalue_o, got.cnt);
    endtask

    initial begin
        exp_t e;
        int   n;
        bus.cal_start_i = 1'b0;
        bus.pattern_i   = 14'h2A5C;
        for (int k = 0; k < NL; k++) pass_mask[k] = win(10, 20);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_idelayctrl_rst", bus.idelayctrl_rst_o, 1'b0);
        chk("rst_cntvalue",       bus.cntvalue_o, '0);
        chk("rst_ld",             bus.ld_o, 1'b0);
        chk("rst_busy",           bus.busy_o, 1'b0);
        chk("rst_done",           bus.done_o, 1'b0);
        chk("rst_fail",           bus.fail_o, '0);
        chk("rst_err",            bus.err_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // All lanes pass 10..20, RDY three cycles after RST falls.
        e = '{tag: "win10_20", cnt: rep(5'd15), fail: '0, err: 1'b0,
              ld_n: 33, rst_n: 16, lat: 16 + 1 + 32 * 266 + 1 + 3};
        run_cal(e, 3, 1'b0);

        // Lane 0 two windows, lane 1 full sweep, lane 3 tied windows.
        pass_mask[0] = win(2, 5) | win(20, 29);
        pass_mask[1] = win(0, 31);
        pass_mask[3] = win(4, 7) | win(12, 15);
        e = '{tag: "multi_win", cnt: rep(5'd15), fail: '0, err: 1'b0,
              ld_n: 33, rst_n: 16, lat: 16 + 1 + 32 * 266 + 1};
        e.cnt[0 +: 5]  = 5'd24;
        e.cnt[15 +: 5] = 5'd5;
        run_cal(e, 0, 1'b0);

        // Lane 7 never matches; a start pulse mid-run is ignored.
        for (int k = 0; k < NL; k++) pass_mask[k] = win(8, 9);
        pass_mask[7] = '0;
        e = '{tag: "lane7_dead", cnt: rep(5'd8), fail: 14'h0080, err: 1'b0,
              ld_n: 33, rst_n: 16, lat: 16 + 1 + 32 * 266 + 1};
        e.cnt[35 +: 5] = 5'd0;
        run_cal(e, 0, 1'b1);

        // Reset during CHECK at tap 17.
        for (int k = 0; k < NL; k++) pass_mask[k] = win(10, 20);
        @(negedge clk);
        bus.cal_start_i = 1'b1;
        @(negedge clk);
        bus.cal_start_i = 1'b0;
        n = 0;
        while (!(bus.ld_o && bus.cntvalue_o[4:0] == 5'd17) && n < 10000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrst_reach_tap17", n < 10000, 1'b1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_idelayctrl_rst", bus.idelayctrl_rst_o, 1'b0);
        chk("midrst_cntvalue",       bus.cntvalue_o, '0);
        chk("midrst_ld",             bus.ld_o, 1'b0);
        chk("midrst_busy",           bus.busy_o, 1'b0);
        chk("midrst_done",           bus.done_o, 1'b0);
        chk("midrst_fail",           bus.fail_o, '0);
        chk("midrst_err",            bus.err_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        e = '{tag: "restart", cnt: rep(5'd15), fail: '0, err: 1'b0,
              ld_n: 33, rst_n: 16, lat: 16 + 1 + 32 * 266 + 1};
        run_cal(e, 0, 1'b0);

`ifdef IDELAY_CAL_RDY_TIMEOUT_EN
        rdy_hold_low = 1'b1;
        e = '{tag: "rdy_timeout", cnt: rep(5'd15), fail: '1, err: 1'b1,
              ld_n: 0, rst_n: 16, lat: 16 + 4096};
        run_cal(e, 0, 1'b0);
        rdy_hold_low = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
